// File: rtl/ps2_keybuf_pkg.sv
// Shared decoder states, PS/2 set-2 byte constants and key-event entry layout for ps2_keybuf.
package ps2_keybuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP
    } dec_state_e;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;

    localparam int ENTRY_W   = 10;
    localparam int ENTRY_REL = 9;
    localparam int ENTRY_EXT = 8;

    // Pause is E1 followed by seven more bytes that carry no extra information.
    localparam logic [2:0] SKIP_LEN = 3'd7;

    // Controller replies and error codes that never describe a key.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
               (b == BYTE_EE) || (b == BYTE_00) || (b == BYTE_FF);
    endfunction

endpackage

// File: rtl/ps2_keybuf_fifo.sv
// First-word-fall-through event FIFO; a pop in the same cycle frees room for a push into a full FIFO.
module ps2_keybuf_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  pop_en;
    logic                  wr_en;

    assign empty = (count_q == '0);
    assign full  = count_q[DEPTH_LOG2];
    assign count = count_q;
    // Storage is not reset, so hide stale contents while empty.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_en   = pop && !empty && !clr;
        wr_en    = push && !clr && (!full || pop_en);
        drop     = push && !clr && !wr_en;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en && !pop_en) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ps2_keybuf.sv
// PS/2 set-2 byte-to-key-event decoder with event FIFO for CPU polling.
// Define KEYBUF_MODS_EN to track alt/ctrl/shift held state on the mods output.
module ps2_keybuf
    import ps2_keybuf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            ps2_data,
    input  logic                  ps2_hit,
    input  logic                  rd,
    input  logic                  clr,
    output logic [ENTRY_W-1:0]    q,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [2:0]            mods
);

    logic             hit_q;
    logic             accept;
    dec_state_e       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic             overflow_q, overflow_d;
    logic             ev_vld;
    logic             ev_rel;
    logic             ev_ext;
    logic [7:0]       ev_code;
    logic [ENTRY_W-1:0] ev_entry;
    logic             fifo_full;
    logic             fifo_drop;

    // One byte per rising edge of the strobe, however long it stays high.
    assign accept = ps2_hit && !hit_q;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_vld  = 1'b0;
        ev_rel  = 1'b0;
        ev_ext  = 1'b0;
        ev_code = ps2_data;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == BYTE_E0) begin
                        state_d = ST_E0;
                    end else if (ps2_data == BYTE_F0) begin
                        state_d = ST_F0;
                    end else if (ps2_data == BYTE_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_LEN;
                    end else if (!is_discard(ps2_data)) begin
                        ev_vld = 1'b1;
                    end
                end
                ST_E0: begin
                    if (ps2_data == BYTE_F0) begin
                        state_d = ST_E0F0;
                    end else begin
                        state_d = ST_IDLE;
                        ev_vld  = (ps2_data != KEY_LSHIFT);
                        ev_ext  = 1'b1;
                    end
                end
                ST_F0: begin
                    state_d = ST_IDLE;
                    ev_vld  = 1'b1;
                    ev_rel  = 1'b1;
                end
                ST_E0F0: begin
                    state_d = ST_IDLE;
                    ev_vld  = (ps2_data != KEY_LSHIFT);
                    ev_rel  = 1'b1;
                    ev_ext  = 1'b1;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = ST_IDLE;
                        ev_vld  = 1'b1;
                        ev_ext  = 1'b1;
                        ev_code = BYTE_E1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (clr) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            ev_vld  = 1'b0;
        end
    end

    always_comb begin
        ev_entry            = '0;
        ev_entry[ENTRY_REL] = ev_rel;
        ev_entry[ENTRY_EXT] = ev_ext;
        ev_entry[7:0]       = ev_code;
        overflow_d          = clr ? 1'b0 : (overflow_q || fifo_drop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q      <= 1'b0;
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            hit_q      <= ps2_hit;
            state_q    <= state_d;
            skip_q     <= skip_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef KEYBUF_MODS_EN
    logic [2:0] mods_q, mods_d;

    // Follows every decoded event, including ones the FIFO had to drop.
    always_comb begin
        mods_d = mods_q;
        if (ev_vld) begin
            if (ev_code == KEY_LSHIFT || ev_code == KEY_RSHIFT) begin
                mods_d[0] = !ev_rel;
            end else if (ev_code == KEY_CTRL) begin
                mods_d[1] = !ev_rel;
            end else if (ev_code == KEY_ALT) begin
                mods_d[2] = !ev_rel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mods_q <= '0;
        end else begin
            mods_q <= mods_d;
        end
    end

    assign mods = mods_q;
`else
    assign mods = 3'b000;
`endif

    ps2_keybuf_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset_n),
        .clr   (clr),
        .push  (ev_vld),
        .pop   (rd),
        .din   (ev_entry),
        .dout  (q),
        .empty (empty),
        .full  (fifo_full),
        .count (count),
        .drop  (fifo_drop)
    );

    // Full status is already folded into drop; kept visible for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
